// File: rtl/bus_arbiter.sv
// Round-robin arbiter for one shared downstream resource.
// Grants are held until done, requester withdrawal, or HOLD_MAX cycles, then one GAP cycle.
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW      = $clog2(HOLD_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            busy,
  output logic            timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [NREQ-1:0] gnt_n;
  logic [IW-1:0]   id_n;
  logic            busy_n, to_n;

  logic [IW-1:0]   win;
  logic            found;
  logic [IW:0]     idx;
  logic            at_max;

  // Rotating priority search: scan offsets high-to-low so the nearest set bit from ptr wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (req[idx[IW-1:0]]) begin
        win   = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end

  assign at_max = (cnt == CW'(HOLD_MAX));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = gnt;
    id_n    = gnt_id;
    busy_n  = busy;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << win;
          id_n    = win;
          busy_n  = 1'b1;
          cnt_n   = CW'(1);
          ptr_n   = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
        end
      end
      GRANT: begin
        if (done || !req[gnt_id] || at_max) begin
          state_n = GAP;
          gnt_n   = '0;
          id_n    = '0;
          busy_n  = 1'b0;
          cnt_n   = '0;
          // Forced release only; a coincident done counts as normal completion.
          to_n    = at_max && !done && req[gnt_id];
        end else begin
          cnt_n   = at_max ? cnt : cnt + CW'(1);
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      gnt_id  <= id_n;
      busy    <= busy_n;
      timeout <= to_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scenario bench for bus_arbiter: per-cycle expected outputs queued with stimulus, compared after each edge.
module tb_bus_arbiter;

  localparam int NREQ = 4;
  localparam int HM   = 8;
  localparam int IW   = 2;
  localparam int OW   = NREQ + IW + 2;

  typedef logic [OW-1:0] ovec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic            done = 1'b0;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_id;
  logic            busy;
  logic            timeout;

  int nchk = 0;
  int npass = 0;
  ovec_t exp_q[$];

  bus_arbiter #(.NREQ(NREQ), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Expected-output packer: {gnt, gnt_id, busy, timeout}.
  function automatic ovec_t mk(int id, bit b, bit t);
    logic [NREQ-1:0] g;
    g = b ? (NREQ'(1) << id) : '0;
    return {g, (b ? IW'(id) : IW'(0)), b, t};
  endfunction

  task automatic test_reset();
    ovec_t e, got;
    for (int c = 0; c < 3; c++) begin
      rst = (c < 2); req = (c < 2) ? 4'b1111 : 4'b0000; done = (c < 2);
      exp_q.push_back(mk(0, 0, 0));
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, timeout}; e = exp_q.pop_front(); nchk++;
      if (got !== e) $display("FAIL reset c%0d got=%b exp=%b", c, got, e); else npass++;
    end
  endtask

  // req=0010, done on the 3rd grant edge, regrant two edges later, then withdraw.
  task automatic test_single();
    ovec_t e, got;
    for (int c = 0; c < 8; c++) begin
      rst = 0; req = (c < 6) ? 4'b0010 : 4'b0000; done = (c == 3);
      if (c < 3 || c == 5) exp_q.push_back(mk(1, 1, 0));
      else                 exp_q.push_back(mk(0, 0, 0));
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, timeout}; e = exp_q.pop_front(); nchk++;
      if (got !== e) $display("FAIL single c%0d got=%b exp=%b", c, got, e); else npass++;
    end
  endtask

  // Reset restores ptr 0; all requesting, done in each grant's 2nd cycle -> 0,1,2,3,0.
  task automatic test_round_robin();
    ovec_t e, got;
    rst = 1; req = '0; done = 0;
    @(posedge clk); #1;
    for (int g = 0; g < 5; g++) begin
      for (int p = 0; p < 4; p++) begin
        rst = 0; req = 4'b1111; done = (p == 2);
        exp_q.push_back(p < 2 ? mk(g % NREQ, 1, 0) : mk(0, 0, 0));
        @(posedge clk); #1;
        got = {gnt, gnt_id, busy, timeout}; e = exp_q.pop_front(); nchk++;
        if (got !== e) $display("FAIL round_robin g%0d p%0d got=%b exp=%b", g, p, got, e);
        else npass++;
      end
    end
    req = '0;
  endtask

  // ptr is 1 here; req=0100 never done -> 8 grant cycles, one timeout cycle, then idle.
  task automatic test_timeout();
    ovec_t e, got;
    for (int c = 0; c < 10; c++) begin
      rst = 0; req = 4'b0100; done = (c == 9);
      if (c < HM)       exp_q.push_back(mk(2, 1, 0));
      else if (c == HM) exp_q.push_back(mk(0, 0, 1));
      else              exp_q.push_back(mk(0, 0, 0));
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, timeout}; e = exp_q.pop_front(); nchk++;
      if (got !== e) $display("FAIL timeout c%0d got=%b exp=%b", c, got, e); else npass++;
    end
  endtask

  // done coincides with counter reaching HOLD_MAX: plain release; then done in IDLE is ignored.
  task automatic test_simultaneous();
    ovec_t e, got;
    for (int c = 0; c < 11; c++) begin
      rst = 0; req = (c < 9) ? 4'b0100 : 4'b0000; done = (c == HM) || (c >= 9);
      exp_q.push_back(c < HM ? mk(2, 1, 0) : mk(0, 0, 0));
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, timeout}; e = exp_q.pop_front(); nchk++;
      if (got !== e) $display("FAIL simultaneous c%0d got=%b exp=%b", c, got, e); else npass++;
    end
  endtask

  // Requester 3 granted; other req bits toggle without effect; withdrawal releases with no timeout.
  task automatic test_withdraw();
    ovec_t e, got;
    for (int c = 0; c < 5; c++) begin
      rst = 0; done = 0;
      case (c)
        0:       req = 4'b1000;
        1, 2:    req = 4'b1011;
        default: req = 4'b0000;
      endcase
      exp_q.push_back(c < 3 ? mk(3, 1, 0) : mk(0, 0, 0));
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, timeout}; e = exp_q.pop_front(); nchk++;
      if (got !== e) $display("FAIL withdraw c%0d got=%b exp=%b", c, got, e); else npass++;
    end
  endtask

  // ptr is 0; grant to 1, reset mid-grant with req=1111, then first grant restarts at 0.
  task automatic test_reset_mid();
    ovec_t e, got;
    for (int c = 0; c < 6; c++) begin
      rst = (c == 2); req = (c < 2) ? 4'b0010 : 4'b1111; done = (c == 4);
      case (c)
        0, 1:    exp_q.push_back(mk(1, 1, 0));
        3:       exp_q.push_back(mk(0, 1, 0));
        default: exp_q.push_back(mk(0, 0, 0));
      endcase
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, timeout}; e = exp_q.pop_front(); nchk++;
      if (got !== e) $display("FAIL reset_mid c%0d got=%b exp=%b", c, got, e); else npass++;
    end
    req = '0; done = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_withdraw();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
